// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg
// Shared definitions for the bit-serial magnitude comparator:
//   cmp_state_t    - controller states (IDLE, SHIFT, DONE)
//   WIDTH_DEFAULT  - default operand width
//   EQ_RST/GT_RST  - result flag values after reset and at the start of
//                    every comparison ("nothing differs yet")
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cmp_state_t;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic EQ_RST = 1'b1;
  localparam logic GT_RST = 1'b0;

endpackage : serial_cmp_pkg

// File: rtl/serial_cmp_bit_update.sv
// serial_cmp_bit_update
// Combinational next-state of the compare flags for one consumed bit pair.
// Flag convention: eq means A == B, gt means B > A.
//
// Build option: SERIAL_CMP_MSB_FIRST_EN
//   undefined - bits arrive LSB first; any differing bit overwrites the
//               decision because it is more significant than all earlier ones.
//   defined   - bits arrive MSB first; cascade rule, the first difference
//               is final.
//
// Ports:
//   a_bit, b_bit   in  current bit of A and B
//   eq_in, gt_in   in  flags accumulated so far
//   eq_out, gt_out out flags after this pair
module serial_cmp_bit_update (
  input  logic a_bit,
  input  logic b_bit,
  input  logic eq_in,
  input  logic gt_in,
  output logic eq_out,
  output logic gt_out
);

`ifdef SERIAL_CMP_MSB_FIRST_EN
  // Once eq drops, gt is frozen: later (less significant) bits are ignored.
  always_comb begin
    eq_out = eq_in & (a_bit == b_bit);
    gt_out = gt_in | (eq_in & b_bit & ~a_bit);
  end
`else
  // A difference at this position outranks everything seen so far,
  // and B is the larger operand exactly when its bit is the 1.
  always_comb begin
    eq_out = eq_in;
    gt_out = gt_in;
    if (a_bit != b_bit) begin
      eq_out = 1'b0;
      gt_out = b_bit;
    end
  end
`endif

endmodule : serial_cmp_bit_update

// File: rtl/serial_lsb_comparator.sv
// serial_lsb_comparator
// Bit-serial magnitude comparator for two unsigned WIDTH-bit operands,
// one bit pair per accepted cycle. Bit order and update rule are chosen by
// the build option SERIAL_CMP_MSB_FIRST_EN (see serial_cmp_bit_update);
// default build is LSB first.
//
// Parameters:
//   WIDTH      operand width, 2..64
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      begin a comparison (honoured in IDLE or DONE only)
//   bit_valid  a_bit/b_bit hold a valid pair (consumed in SHIFT only)
//   a_bit      current bit of A
//   b_bit      current bit of B
//   busy       high while in SHIFT
//   done       one-cycle pulse on the cycle DONE is entered
//   eq         A == B, valid when not busy
//   gt         B > A,  valid when not busy
module serial_lsb_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic eq,
  output logic gt
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  cmp_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic             upd_eq, upd_gt;

  serial_cmp_bit_update u_bit_update (
    .a_bit  (a_bit),
    .b_bit  (b_bit),
    .eq_in  (eq_q),
    .gt_in  (gt_q),
    .eq_out (upd_eq),
    .gt_out (upd_gt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    done_d  = 1'b0;

    unique case (state_q)
      // A pair presented together with start is not consumed: the first
      // pair is only sampled once the FSM is already in SHIFT.
      IDLE, DONE: begin
        if (start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          eq_d    = EQ_RST;
          gt_d    = GT_RST;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          eq_d  = upd_eq;
          gt_d  = upd_gt;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs follow the state being entered.
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= EQ_RST;
      gt_q    <= GT_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule : serial_lsb_comparator

// File: tb/tb_serial_lsb_comparator.sv
// tb_serial_lsb_comparator
// Drives randomized and directed comparisons into an 8-bit comparator and
// directed ones into a 2-bit instance. A transaction-level model (collects
// the operand bits, then compares whole numbers) is checked against the
// 8-bit DUT on every falling edge. Honours SERIAL_CMP_MSB_FIRST_EN for the
// order in which operand bits are serialised.
module tb_serial_lsb_comparator;

  localparam int W = 8;

`ifdef SERIAL_CMP_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;
  logic busy, done, eq, gt;

  logic s2_start = 1'b0, s2_valid = 1'b0, s2_a = 1'b0, s2_b = 1'b0;
  logic s2_busy, s2_done, s2_eq, s2_gt;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  serial_lsb_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit),
    .busy(busy), .done(done), .eq(eq), .gt(gt)
  );

  serial_lsb_comparator #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .bit_valid(s2_valid),
    .a_bit(s2_a), .b_bit(s2_b),
    .busy(s2_busy), .done(s2_done), .eq(s2_eq), .gt(s2_gt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Serial position of operand bit for the i-th pair of a width-w operand.
  function automatic int bit_idx(input int i, input int w);
    return MSB_FIRST ? (w - 1 - i) : i;
  endfunction

  // ---------------- transaction-level model ----------------
  // phase: 0 waiting for start, 1 collecting bits, 2 finished
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [63:0] m_a = '0, m_b = '0;
  logic        m_eq = 1'b1, m_gt = 1'b0, m_done = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_eq = 1'b1; m_gt = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_phase != 1) begin
        if (start) begin
          m_phase = 1; m_cnt = 0; m_a = '0; m_b = '0; m_eq = 1'b1; m_gt = 1'b0;
        end
      end else if (bit_valid) begin
        m_a[bit_idx(m_cnt, W)] = a_bit;
        m_b[bit_idx(m_cnt, W)] = b_bit;
        m_cnt++;
        if (m_cnt == W) begin
          m_phase = 2;
          m_done  = 1'b1;
          m_eq    = (m_a == m_b);
          m_gt    = (m_b > m_a);
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      check("busy", busy, (m_phase == 1));
      check("done", done, m_done);
      check("eq_gt_exclusive", eq & gt, 1'b0);
      if (m_phase != 1) begin
        check("eq", eq, m_eq);
        check("gt", gt, m_gt);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at a falling edge. Asserts start for one cycle (with a junk
  // pair alongside), then feeds W pairs. stall_mode: 0 none, 1 one stall
  // before every pair, 2 random stalls. Returns edges from the start edge
  // to the edge that consumed the last pair, plus flags after pair one.
  task automatic run_cmp(input logic [63:0] a, input logic [63:0] b, input int stall_mode,
                         output int cycles, output logic first_eq, output logic first_gt);
    int n;
    start = 1'b1; bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
    @(negedge clk);
    cycles = 0;
    first_eq = 1'bx; first_gt = 1'bx;
    for (int i = 0; i < W; i++) begin
      n = (stall_mode == 1) ? 1 : (stall_mode == 2) ? $urandom_range(0, 3) : 0;
      for (int s = 0; s < n; s++) begin
        bit_valid = 1'b0; a_bit = 1'($urandom); b_bit = 1'($urandom);
        start = ($urandom_range(0, 5) == 0);
        @(negedge clk); cycles++;
      end
      bit_valid = 1'b1;
      a_bit = a[bit_idx(i, W)];
      b_bit = b[bit_idx(i, W)];
      start = (stall_mode != 0) && ($urandom_range(0, 5) == 0);
      @(negedge clk); cycles++;
      if (i == 0) begin first_eq = eq; first_gt = gt; end
    end
    start = 1'b0; bit_valid = 1'b0;
    $display("txn A=%02h B=%02h stall=%0d cycles=%0d done=%b eq=%b gt=%b",
             a[7:0], b[7:0], stall_mode, cycles, done, eq, gt);
  endtask

  initial begin
    int          cyc;
    logic        f_eq, f_gt;
    logic [63:0] ra, rb;
    logic [1:0]  a2, b2;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_eq", eq, 1'b1);
    check("rst_gt", gt, 1'b0);

    // Equal operands, no stalls.
    run_cmp(64'h5A, 64'h5A, 0, cyc, f_eq, f_gt);
    check("eq5a_latency", cyc, W);
    check("eq5a_done", done, 1'b1);
    check("eq5a_eq", eq, 1'b1);
    check("eq5a_gt", gt, 1'b0);
    check("eq5a_model_eq", m_eq, 1'b1);

    // Back-to-back start while done is high.
    run_cmp(64'h01, 64'h80, 0, cyc, f_eq, f_gt);
    check("b2b_latency", cyc, W);
    check("first_pair_eq", f_eq, 1'b0);
    check("first_pair_gt", f_gt, MSB_FIRST ? 1'b1 : 1'b0);
    check("x01_80_eq", eq, 1'b0);
    check("x01_80_gt", gt, 1'b1);
    check("x01_80_model_gt", m_gt, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("held_gt", gt, 1'b1);

    // Alternating stalls.
    run_cmp(64'hF0, 64'h0F, 1, cyc, f_eq, f_gt);
    check("stall_latency", cyc, 2 * W);
    check("stall_done", done, 1'b1);
    check("f0_0f_eq", eq, 1'b0);
    check("f0_0f_gt", gt, 1'b0);

    // bit_valid in DONE/IDLE must be ignored.
    repeat (4) begin
      @(negedge clk);
      bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = 1'($urandom);
    end
    @(negedge clk);
    bit_valid = 1'b0;
    check("idle_valid_busy", busy, 1'b0);
    check("idle_valid_gt", gt, 1'b0);

    // Reset in the middle of a comparison.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      a_bit = MSB_FIRST ? 1'b1 : 1'b1;
      b_bit = 1'b0;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_eq", eq, 1'b1);
    check("midrst_gt", gt, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized comparisons with random gaps.
    for (int t = 0; t < 40; t++) begin
      ra = 64'($urandom_range(0, 255));
      rb = ($urandom_range(0, 3) == 0) ? ra : 64'($urandom_range(0, 255));
      run_cmp(ra, rb, 2, cyc, f_eq, f_gt);
      check("rand_done", done, 1'b1);
      check("rand_result", {eq, gt}, {ra == rb, rb > ra});
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bit_valid = 1'($urandom); a_bit = 1'($urandom); b_bit = 1'($urandom);
      end
      bit_valid = 1'b0;
    end

    // WIDTH=2 boundary: A=2, B=3.
    a2 = 2'd2; b2 = 2'd3;
    @(negedge clk);
    s2_start = 1'b1;
    @(negedge clk);
    s2_start = 1'b0;
    check("w2_busy", s2_busy, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check("w2_not_done", s2_done, 1'b0);
      s2_valid = 1'b1;
      s2_a = a2[bit_idx(i, 2)];
      s2_b = b2[bit_idx(i, 2)];
      @(negedge clk);
    end
    s2_valid = 1'b0;
    $display("txn W2 A=2 B=3 done=%b eq=%b gt=%b", s2_done, s2_eq, s2_gt);
    check("w2_done", s2_done, 1'b1);
    check("w2_busy_end", s2_busy, 1'b0);
    check("w2_eq", s2_eq, 1'b0);
    check("w2_gt", s2_gt, 1'b1);
    @(negedge clk);
    check("w2_done_pulse", s2_done, 1'b0);

    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_lsb_comparator

// File: doc/serial_lsb_comparator.md
Name: serial_lsb_comparator

Overview:
- Sequential bit-serial magnitude comparator for two unsigned WIDTH-bit operands A and B, fed one bit pair per accepted cycle, LSB first.
- It is the opposite-direction counterpart to the MSB-first combinational compare cascade already in the design.
- It uses the same flag convention: eq means A == B, gt means B > A.
- It sits between serializing sources and control logic that needs a compare result without a WIDTH-bit parallel datapath.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1): bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new comparison; honoured only in IDLE or DONE.
- bit_valid  input  1  a_bit/b_bit carry a valid pair this cycle.
- a_bit  input  1  current bit of A.
- b_bit  input  1  current bit of B.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the WIDTH-th pair is consumed.
- eq  output  1  result: A == B; valid when not busy.
- gt  output  1  result: B > A; valid when not busy.

Behaviour:
- Reset: state=IDLE, cnt=0, busy=0, done=0, eq=1, gt=0.
  - Reset is asynchronous and active-high, and aborts any comparison in progress.
- States:
  - IDLE: start=1 -> SHIFT; eq<=1, gt<=0, cnt<=0.
  - SHIFT: busy=1.
    - Each cycle with bit_valid=1, one pair is consumed and cnt increments.
    - bit_valid=0 is a stall: no state change.
    - When the pair consumed makes cnt reach WIDTH -> DONE, with done=1 in the cycle DONE is entered.
  - DONE: done=0 after its single cycle; eq/gt are held.
    - start=1 -> SHIFT with the same initialisation as IDLE.
    - Otherwise stay in DONE.
- LSB-first update rule (per consumed pair):
  - If a_bit != b_bit: eq<=0 and gt<=b_bit. A more significant differing bit overrides any earlier decision.
  - If a_bit == b_bit: eq and gt are unchanged.
- Latency: done asserts on the clock edge that consumes pair WIDTH. With no stalls, that is WIDTH cycles after the start edge.
- start while busy is ignored; bit_valid outside SHIFT is ignored.
- start and the first bit_valid in the same cycle (IDLE/DONE): the pair is NOT consumed. The first pair is sampled in the cycle after start.
- eq/gt mid-operation reflect the partial result and are not contractually valid until done.
- Invariant: eq and gt are never both 1.

Optional Feature:
- Macro SERIAL_CMP_MSB_FIRST_EN.
- Defined: bits arrive MSB first and the update rule becomes the cascade rule.
  - Next eq = eq & (a_bit == b_bit).
  - Next gt = gt | (eq & b_bit & ~a_bit).
  - The first difference is final; later bits cannot change the result.
- Undefined: LSB-first rule as above.
- Ports, timing and handshake are identical in both builds.

Decomposition:
- Package serial_cmp_pkg holds:
  - State enum cmp_state_t {IDLE, SHIFT, DONE}.
  - WIDTH default constant.
  - Reset values for eq and gt.
- Sub-module serial_cmp_bit_update: combinational next eq/gt from (a_bit, b_bit, eq, gt). The macro selects its rule. The top block holds the FSM, counter and registers.

Test Plan:
- Reset during SHIFT after 3 pairs -> immediately busy=0, done=0, eq=1, gt=0, state IDLE.
- WIDTH=8, A=0x5A, B=0x5A, no stalls -> done at cycle 8 after start; eq=1, gt=0.
- A=0x01, B=0x80, LSB-first -> early partial gt=0, final eq=0, gt=1.
  - Same operands with SERIAL_CMP_MSB_FIRST_EN -> same final result, fixed after the first pair.
- A=0xF0, B=0x0F with bit_valid low on alternate cycles -> done after exactly 8 consumed pairs (16 cycles); eq=0, gt=0.
- start pulsed during SHIFT and bit_valid asserted in IDLE -> both ignored. Back-to-back start in DONE restarts with eq=1, gt=0; done is exactly one cycle per comparison.
- WIDTH=2 boundary: A=2, B=3 -> done after 2 pairs; gt=1, eq=0.
